dot_product_accumulator: RTL and testbench

- Downstream consumer of the 4-element pipelined dot-product stage. That stage emits one 10-bit partial sum per cycle.
- This block sums NUM_CHUNKS consecutive partials into one long dot product, covering vectors of length 4*NUM_CHUNKS.
- It presents each result on a valid/ready output port with a single holding register.
- The upstream pipeline cannot stall, so this block never back-pressures its input. Results that cannot be delivered are dropped and flagged.

---
 rtl/dot_product_pkg.sv | 17 +
 rtl/dot_product_accumulator_out_reg.sv | 45 ++++
 rtl/dot_product_accumulator.sv | 76 +++++++
 tb/tb_dot_product_accumulator.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/dot_product_pkg.sv
// Shared widths for the dot-product pipeline: upstream 4-lane stage and
// downstream accumulator. No ports; constants and a width helper only.
package dot_product_pkg;

  localparam int DP_LANES  = 4;
  localparam int DP_ELEM_W = 4;
  localparam int DP_PROD_W = 2 * DP_ELEM_W;
  localparam int DP_IN_W   = 10;

  function automatic int dp_out_w(
    input int in_w,
    input int chunks
  );
    return in_w + $clog2(chunks);
  endfunction

endpackage

// File: rtl/dot_product_accumulator_out_reg.sv
// One-entry valid/ready holding register for pipeline tails that cannot stall.
// Ports: clk/rst (sync), clr (clears drop flag), load/data (new result),
// ready (consumer), q/valid (held result), overflow (sticky drop flag).
module dp_out_reg #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] data,
  input  logic         ready,
  output logic [W-1:0] q,
  output logic         valid,
  output logic         overflow
);

  logic take;
  logic drop;

  // A full register still accepts new data when it drains this same edge.
  assign take = load && (!valid || ready);
  assign drop = load && valid && !ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      q        <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (take) begin
        q     <= data;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
      if (clr) begin
        overflow <= 1'b0;
      end else if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/dot_product_accumulator.sv
// Sums NUM_CHUNKS consecutive upstream partials into one dot product.
// Ports: i_clk/i_rst (sync), i_valid/i_partial (beats), i_clr (abort),
// o_sum/o_valid/i_ready (result port), o_chunk_cnt, o_overflow (sticky drop).
module dot_product_accumulator
  import dot_product_pkg::*;
#(
  parameter int NUM_CHUNKS = 4,
  parameter int IN_W       = DP_IN_W
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_valid,
  input  logic [IN_W-1:0]             i_partial,
  input  logic                        i_clr,
  output logic [dp_out_w(IN_W, NUM_CHUNKS)-1:0] o_sum,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [$clog2(NUM_CHUNKS):0] o_chunk_cnt,
  output logic                        o_overflow
);

  localparam int OUT_W = dp_out_w(IN_W, NUM_CHUNKS);
  localparam int CNT_W = $clog2(NUM_CHUNKS) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_CHUNKS - 1);

  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] sum_next;
  logic [CNT_W-1:0] chunk_cnt;
  logic             beat;
  logic             first;
  logic             last;
  logic             done;

  // i_clr wins over a coincident beat.
  assign beat  = i_valid && !i_clr;
  assign first = (chunk_cnt == '0);
  assign last  = (chunk_cnt == LAST);
  assign done  = beat && last;

  // The first beat overwrites acc, so acc never needs an explicit clear.
  assign sum_next = first ? OUT_W'(i_partial)
                          : acc + OUT_W'(i_partial);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc       <= '0;
      chunk_cnt <= '0;
    end else if (i_clr) begin
      chunk_cnt <= '0;
    end else if (beat) begin
      acc <= sum_next;
      if (last) begin
        chunk_cnt <= '0;
      end else begin
        chunk_cnt <= chunk_cnt + 1'b1;
      end
    end
  end

  assign o_chunk_cnt = chunk_cnt;

  dp_out_reg #(
    .W(OUT_W)
  ) u_out (
    .clk      (i_clk),
    .rst      (i_rst),
    .clr      (i_clr),
    .load     (done),
    .data     (sum_next),
    .ready    (i_ready),
    .q        (o_sum),
    .valid    (o_valid),
    .overflow (o_overflow)
  );

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Scoreboard bench for dot_product_accumulator (default and NUM_CHUNKS=1).
// Stimulus pushes expected results; a negedge monitor checks handshakes.
module tb_dot_product_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [9:0]  partial;
  logic        clr;
  logic        ready;
  logic [11:0] sum;
  logic        sum_valid;
  logic [2:0]  cnt;
  logic        ovf;
  logic [9:0]  sum1;
  logic        sum1_valid;
  logic [0:0]  cnt1;
  logic        ovf1;

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  dot_product_accumulator #(.NUM_CHUNKS(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid),
    .i_partial(partial), .i_clr(clr), .o_sum(sum),
    .o_valid(sum_valid), .i_ready(ready),
    .o_chunk_cnt(cnt), .o_overflow(ovf)
  );

  dot_product_accumulator #(.NUM_CHUNKS(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid),
    .i_partial(partial), .i_clr(clr), .o_sum(sum1),
    .o_valid(sum1_valid), .i_ready(ready),
    .o_chunk_cnt(cnt1), .o_overflow(ovf1)
  );

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic v, input int p, input logic c = 1'b0);
    valid   = v;
    partial = 10'(p);
    clr     = c;
    @(posedge clk);
    #1;
  endtask

  // Monitor: a handshake completes at the next edge when valid && ready.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && sum_valid && ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", int'(sum), -1);
        end else begin
          check("scoreboard_sum", int'(sum), exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1; valid = 1'b0; partial = '0; clr = 1'b0; ready = 1'b1;
    cyc(0, 0); cyc(0, 0);
    check("rst_valid", int'(sum_valid), 0);
    check("rst_sum", int'(sum), 0);
    check("rst_cnt", int'(cnt), 0);
    check("rst_ovf", int'(ovf), 0);
    rst = 1'b0;

    // 10+20+30+40
    cyc(1, 10); cyc(1, 20); cyc(1, 30);
    check("cnt_3", int'(cnt), 3);
    exp_q.push_back(100);
    cyc(1, 40);
    check("t1_valid", int'(sum_valid), 1);
    check("t1_sum", int'(sum), 100);
    check("t1_cnt", int'(cnt), 0);
    cyc(0, 0);
    check("t1_valid_drop", int'(sum_valid), 0);

    // Back-to-back max vectors
    exp_q.push_back(4092);
    exp_q.push_back(4092);
    for (int i = 0; i < 8; i++) cyc(1, 1023);
    check("t2_valid", int'(sum_valid), 1);
    check("t2_sum", int'(sum), 4092);
    check("t2_ovf", int'(ovf), 0);
    cyc(0, 0);

    // Stalled consumer: second result is dropped
    ready = 1'b0;
    exp_q.push_back(10);
    cyc(1, 1); cyc(1, 2); cyc(1, 3); cyc(1, 4);
    check("t3_ovf_first", int'(ovf), 0);
    for (int i = 0; i < 4; i++) cyc(1, 5);
    check("t3_sum_hold", int'(sum), 10);
    check("t3_valid_hold", int'(sum_valid), 1);
    check("t3_ovf", int'(ovf), 1);
    cyc(0, 0);
    check("t3_sum_stable", int'(sum), 10);
    ready = 1'b1;
    cyc(0, 0);
    check("t3_drained", int'(sum_valid), 0);
    check("t3_ovf_sticky", int'(ovf), 1);

    // Abort mid-vector
    cyc(1, 7); cyc(1, 8);
    check("t5_cnt_2", int'(cnt), 2);
    cyc(1, 99, 1'b1);
    check("t5_clr_cnt", int'(cnt), 0);
    check("t5_clr_ovf", int'(ovf), 0);
    check("t5_clr_novalid", int'(sum_valid), 0);
    exp_q.push_back(4);
    cyc(1, 1); cyc(1, 1); cyc(1, 1); cyc(1, 1);
    check("t5_sum", int'(sum), 4);
    cyc(0, 0);

    // Completion coincides with handshake of the previous result
    ready = 1'b0;
    exp_q.push_back(4);
    cyc(1, 1); cyc(1, 1); cyc(1, 1); cyc(1, 1);
    cyc(1, 2); cyc(1, 2); cyc(1, 2);
    check("t4_valid_held", int'(sum_valid), 1);
    ready = 1'b1;
    exp_q.push_back(8);
    cyc(1, 2);
    check("t4_valid", int'(sum_valid), 1);
    check("t4_sum", int'(sum), 8);
    check("t4_ovf", int'(ovf), 0);
    cyc(0, 0);
    check("t4_drained", int'(sum_valid), 0);

    // Reset mid-vector
    cyc(1, 5); cyc(1, 5);
    rst = 1'b1;
    cyc(1, 9);
    check("t6_rst_cnt", int'(cnt), 0);
    check("t6_rst_valid", int'(sum_valid), 0);
    check("t6_rst_sum", int'(sum), 0);
    rst = 1'b0;
    exp_q.push_back(8);
    cyc(1, 2); cyc(1, 2); cyc(1, 2); cyc(1, 2);
    check("t6_sum", int'(sum), 8);
    cyc(0, 0);

    // Single-chunk instance
    cyc(1, 513);
    check("n1_valid", int'(sum1_valid), 1);
    check("n1_sum", int'(sum1), 513);
    check("n1_cnt", int'(cnt1), 0);
    cyc(0, 0);
    cyc(0, 0);

    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
